pool_window_sequencer: RTL

//  Sequences the 4-wide threshold pooling stage. It collects convolution results from an

---
 rtl/pool_window_sequencer_pkg.sv | 16 +
 rtl/pool_window_sequencer_if.sv | 29 ++
 rtl/pool_window_sequencer_pos_counter.sv | 40 ++++
 rtl/pool_window_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pool_window_sequencer_pkg.sv
// Shared types and defaults for the threshold-pooling window sequencer.
package pool_pkg;

  localparam int POOL_WIN   = 4;
  localparam int POOL_OUT_W = 8;
  localparam int POOL_OUT_H = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REPLAY,
    RESULT,
    DONE
  } pool_seq_state_t;

endpackage

// File: rtl/pool_window_sequencer_if.sv
// Sample stream in, pooling-stage drive and pooled-result stream out.
interface pool_window_sequencer_if #(
  parameter int DW    = 8,
  parameter int OUT_W = 8,
  parameter int OUT_H = 8
);
  localparam int CW = $clog2(OUT_W);
  localparam int RW = $clog2(OUT_H);

  logic          conv_valid;
  logic [DW-1:0] conv_data;
  logic          conv_ready;
  logic [DW-1:0] pool_data;
  logic          pool_en;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;

  modport master (
    output conv_valid, conv_data, out_ready,
    input  conv_ready, pool_data, pool_en, out_valid, out_col, out_row
  );

  modport slave (
    input  conv_valid, conv_data, out_ready,
    output conv_ready, pool_data, pool_en, out_valid, out_col, out_row
  );
endinterface

// File: rtl/pool_window_sequencer_pos_counter.sv
// Row-major (row, col) position counter over a W x H map with a last-position flag.
module pool_pos_counter #(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [$clog2(W)-1:0] col,
  output logic [$clog2(H)-1:0] row,
  output logic                 last
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (en) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        // The final position wraps to (0,0), ready for the next frame.
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign col  = col_reg;
  assign row  = row_reg;
  assign last = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
endmodule

// File: rtl/pool_window_sequencer.sv
// Collects 4-sample windows, replays them gap-free to the pooling stage and
// hands each pooled position downstream under valid/ready.
module pool_window_sequencer
  import pool_pkg::*;
#(
  parameter int DW    = 8,
  parameter int WIN   = POOL_WIN,
  parameter int OUT_W = POOL_OUT_W,
  parameter int OUT_H = POOL_OUT_H
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  pool_window_sequencer_if.slave  bus,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int FW = $clog2(WIN);
  localparam logic [FW-1:0] LAST_IDX = FW'(WIN - 1);

  pool_seq_state_t state_reg;
  logic [FW-1:0]   fill_reg;
  logic [FW-1:0]   k_reg;
  logic [FW-1:0]   k_inc;
  logic            conv_ready_reg;
  logic [DW-1:0]   pool_data_reg;
  logic            pool_en_reg;
  logic            out_valid_reg;
  logic            busy_reg;
  logic            frame_done_reg;
  logic [DW-1:0]   buf_w [WIN];
  logic            accept;
  logic            result_take;
  logic            pos_clr;
  logic            pos_last;

  assign accept      = bus.conv_valid && conv_ready_reg;
  assign result_take = (state_reg == RESULT) && bus.out_ready;
  assign pos_clr     = (state_reg == IDLE) && start;
  assign k_inc       = k_reg + 1'b1;

  for (genvar gi = 0; gi < WIN; gi++) begin : g_buf
    logic [DW-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (accept && fill_reg == FW'(gi)) entry_reg <= bus.conv_data;
    end
    assign buf_w[gi] = entry_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fill_reg       <= '0;
      k_reg          <= '0;
      conv_ready_reg <= 1'b0;
      pool_data_reg  <= '0;
      pool_en_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= COLLECT;
            fill_reg       <= '0;
            conv_ready_reg <= 1'b1;
            busy_reg       <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            fill_reg <= fill_reg + 1'b1;
            if (fill_reg == LAST_IDX) begin
              // Entry 0 is already stored, so replay can start on the next cycle.
              state_reg      <= REPLAY;
              k_reg          <= '0;
              conv_ready_reg <= 1'b0;
              pool_data_reg  <= buf_w[0];
            end
          end
        end
        REPLAY: begin
          if (k_reg == LAST_IDX) begin
            state_reg     <= RESULT;
            k_reg         <= '0;
            pool_en_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            k_reg         <= k_inc;
            pool_data_reg <= buf_w[k_inc];
            pool_en_reg   <= (k_inc == LAST_IDX);
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (pos_last) begin
              state_reg      <= DONE;
              frame_done_reg <= 1'b1;
            end else begin
              state_reg      <= COLLECT;
              fill_reg       <= '0;
              conv_ready_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  pool_pos_counter #(.W(OUT_W), .H(OUT_H)) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pos_clr),
    .en    (result_take),
    .col   (bus.out_col),
    .row   (bus.out_row),
    .last  (pos_last)
  );

  assign bus.conv_ready = conv_ready_reg;
  assign bus.pool_data  = pool_data_reg;
  assign bus.pool_en    = pool_en_reg;
  assign bus.out_valid  = out_valid_reg;
  assign busy           = busy_reg;
  assign frame_done     = frame_done_reg;
endmodule
